// File: rtl/seq_threshold_neuron.sv
// Sequential step-activation neuron. One weighted binary input is added per
// clock onto the bias. The result is z = (act >= 0).
// Optional feature macro: SEQ_NEURON_SATURATE_EN. When it is defined, each add
// saturates instead of wrapping.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a vector; config writes are accepted
// ACC   | adding one weighted term per cycle, idx 0..N_IN-1
// DONE  | result presented; held until out_ready
module seq_threshold_neuron #(
   parameter int N_IN      = 2,
   parameter int W_WIDTH   = 8,
   parameter int ACC_WIDTH = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cfg_we,
   input  logic [$clog2(N_IN+1)-1:0]     cfg_addr,
   input  logic [W_WIDTH-1:0]            cfg_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [N_IN-1:0]               in_bits,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          out_z,
   output logic [ACC_WIDTH-1:0]          out_act
);

   localparam int AW    = $clog2(N_IN+1);
   localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN-1);

   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

   state_t state_q, state_d;

   logic signed [W_WIDTH-1:0]   weight_q [N_IN];
   logic signed [W_WIDTH-1:0]   bias_q;
   // Weights are masked by in_bits when a vector is accepted. A config write
   // on that same edge therefore cannot affect the vector that is in flight.
   logic signed [W_WIDTH-1:0]   sel_q    [N_IN];
   logic signed [ACC_WIDTH-1:0] acc_q;
   logic [IDX_W-1:0]            idx_q;

   logic signed [ACC_WIDTH-1:0] term;
   logic signed [ACC_WIDTH-1:0] sum;
   logic                        last_term;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state and handshake outputs
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = ACC;
         end
         ACC: begin
            if (last_term) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign last_term = (idx_q == LAST_IDX);

   // Current term, sign-extended, and the accumulate step (wrapping or saturating)
`ifdef SEQ_NEURON_SATURATE_EN
   logic [ACC_WIDTH:0] wide;
   always_comb begin
      term = ACC_WIDTH'(sel_q[idx_q]);
      wide = {acc_q[ACC_WIDTH-1], acc_q} + {term[ACC_WIDTH-1], term};
      sum  = wide[ACC_WIDTH-1:0];
      if (wide[ACC_WIDTH] != wide[ACC_WIDTH-1]) begin
         if (wide[ACC_WIDTH]) sum = {1'b1, {(ACC_WIDTH-1){1'b0}}};
         else                 sum = {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
   end
`else
   always_comb begin
      term = ACC_WIDTH'(sel_q[idx_q]);
      sum  = acc_q + term;
   end
`endif

   // Config registers, vector capture, accumulation and the registered result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_IN; i++) begin
            weight_q[i] <= '0;
            sel_q[i]    <= '0;
         end
         bias_q  <= '0;
         acc_q   <= '0;
         idx_q   <= '0;
         out_act <= '0;
         out_z   <= 1'b0;
      end else begin
         if (state_q == IDLE && cfg_we) begin
            if (cfg_addr == AW'(N_IN)) begin
               bias_q <= cfg_data;
            end else begin
               for (int i = 0; i < N_IN; i++)
                  if (cfg_addr == AW'(i)) weight_q[i] <= cfg_data;
            end
         end
         if (state_q == IDLE && in_valid) begin
            for (int i = 0; i < N_IN; i++)
               sel_q[i] <= in_bits[i] ? weight_q[i] : '0;
            acc_q <= ACC_WIDTH'(bias_q);
            idx_q <= '0;
         end
         if (state_q == ACC) begin
            acc_q <= sum;
            idx_q <= idx_q + IDX_W'(1);
            if (last_term) begin
               out_act <= sum;
               out_z   <= ~sum[ACC_WIDTH-1];
            end
         end
      end
   end

endmodule

// File: tb/tb_seq_threshold_neuron.sv
// Directed bench for seq_threshold_neuron: a table of weight/bias/input
// vectors, then hand-written sequences for backpressure, config timing,
// reset during accumulation, and 8-bit overflow.
module tb_seq_threshold_neuron;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cfg_we = 1'b0;
   logic [1:0] cfg_addr = '0;
   logic [7:0] cfg_data = '0;
   logic       in_valid = 1'b0;
   logic [1:0] in_bits = '0;
   logic       out_ready = 1'b0;

   logic        in_ready, out_valid, out_z;
   logic [15:0] out_act;
   logic        in_ready8, out_valid8, out_z8;
   logic [7:0]  out_act8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_threshold_neuron #(.N_IN(2), .W_WIDTH(8), .ACC_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .in_valid(in_valid), .in_ready(in_ready),
      .in_bits(in_bits), .out_valid(out_valid), .out_ready(out_ready),
      .out_z(out_z), .out_act(out_act)
   );

   // Narrow-accumulator instance. It shares all inputs and runs in lockstep.
   seq_threshold_neuron #(.N_IN(2), .W_WIDTH(8), .ACC_WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .in_valid(in_valid), .in_ready(in_ready8),
      .in_bits(in_bits), .out_valid(out_valid8), .out_ready(out_ready),
      .out_z(out_z8), .out_act(out_act8)
   );

   typedef struct {
      int         w0;
      int         w1;
      int         bias;
      logic [1:0] bits;
      int         act;
      int         z;
   } vec_t;

   vec_t tbl [9];

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic cfg_write(input logic [1:0] addr, input int data);
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = addr; cfg_data = 8'(data);
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic cfg_all(input int w0, input int w1, input int bias);
      cfg_write(2'd0, w0);
      cfg_write(2'd1, w1);
      cfg_write(2'd2, bias);
   endtask

   // Wait a bounded number of cycles for out_valid, capture the outputs,
   // then complete the handshake. Returns at a negedge with the DUT in IDLE.
   task automatic collect(output int act, output int z, output int act8,
                          output int z8, output int lat);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      act  = int'($signed(out_act));
      z    = int'(out_z);
      act8 = int'($signed(out_act8));
      z8   = int'(out_z8);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic run_vec(input logic [1:0] bits, output int act, output int z,
                          output int act8, output int z8, output int lat);
      @(negedge clk);
      in_valid = 1'b1; in_bits = bits;
      @(negedge clk);
      in_valid = 1'b0;
      collect(act, z, act8, z8, lat);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int act, z, act8, z8, lat;

      tbl[0] = '{-10, -10,  10, 2'b11, -10, 0};
      tbl[1] = '{-10, -10,  10, 2'b00,  10, 1};
      tbl[2] = '{-10, -10,  10, 2'b01,   0, 1};
      tbl[3] = '{ 10,  10, -10, 2'b01,   0, 1};
      tbl[4] = '{ 10,  10, -10, 2'b00, -10, 0};
      tbl[5] = '{ 10,  10, -10, 2'b11,  10, 1};
      tbl[6] = '{-100,-100, -5, 2'b10,-105, 0};
      tbl[7] = '{-128,-128,-128,2'b11,-384, 0};
      tbl[8] = '{ 127, 127, 127,2'b11, 381, 1};

      #12;
      chk("reset out_valid", int'(out_valid), 0);
      chk("reset out_z", int'(out_z), 0);
      chk("reset out_act", int'($signed(out_act)), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("reset in_ready", int'(in_ready), 1);

      // Table-driven vectors
      for (int i = 0; i < 9; i++) begin
         cfg_all(tbl[i].w0, tbl[i].w1, tbl[i].bias);
         run_vec(tbl[i].bits, act, z, act8, z8, lat);
         chk($sformatf("vec%0d act", i), act, tbl[i].act);
         chk($sformatf("vec%0d z", i), z, tbl[i].z);
         chk($sformatf("vec%0d latency", i), lat, 2);
      end

      // Backpressure: hold out_ready low for 5 cycles and pulse in_valid
      cfg_all(-10, -10, 10);
      @(negedge clk);
      in_valid = 1'b1; in_bits = 2'b11;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("bp valid rises", int'(out_valid), 1);
      for (int c = 0; c < 5; c++) begin
         in_valid = c[0]; in_bits = 2'b00;
         @(negedge clk);
         chk("bp out_valid", int'(out_valid), 1);
         chk("bp out_act", int'($signed(out_act)), -10);
         chk("bp out_z", int'(out_z), 0);
         chk("bp in_ready", int'(in_ready), 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp release in_ready", int'(in_ready), 1);
      chk("bp release out_valid", int'(out_valid), 0);

      // Config write during ACC is dropped
      cfg_all(10, 10, -10);
      @(negedge clk);
      in_valid = 1'b1; in_bits = 2'b01;
      @(negedge clk);
      in_valid = 1'b0;
      cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 8'd50;
      @(negedge clk);
      cfg_we = 1'b0;
      collect(act, z, act8, z8, lat);
      chk("acc-write vec act", act, 0);
      run_vec(2'b01, act, z, act8, z8, lat);
      chk("acc-write dropped act", act, 0);

      // Weight write on the accepting edge: the vector sees the old weight
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 8'd50;
      in_valid = 1'b1; in_bits = 2'b01;
      @(negedge clk);
      cfg_we = 1'b0; in_valid = 1'b0;
      collect(act, z, act8, z8, lat);
      chk("same-edge w0 old act", act, 0);
      run_vec(2'b01, act, z, act8, z8, lat);
      chk("same-edge w0 landed act", act, 40);
      chk("same-edge w0 landed z", z, 1);

      // Bias write on the accepting edge
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = 2'd2; cfg_data = 8'd20;
      in_valid = 1'b1; in_bits = 2'b00;
      @(negedge clk);
      cfg_we = 1'b0; in_valid = 1'b0;
      collect(act, z, act8, z8, lat);
      chk("same-edge bias old act", act, -10);
      chk("same-edge bias old z", z, 0);
      run_vec(2'b00, act, z, act8, z8, lat);
      chk("same-edge bias landed act", act, 20);

      // An out-of-range address is ignored
      cfg_write(2'd3, 99);
      run_vec(2'b11, act, z, act8, z8, lat);
      chk("bad addr act", act, 80);

      // Reset during ACC clears weights and discards the result
      cfg_all(-10, -10, 10);
      @(negedge clk);
      in_valid = 1'b1; in_bits = 2'b11;
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid reset out_valid", int'(out_valid), 0);
      chk("mid reset in_ready", int'(in_ready), 1);
      chk("mid reset out_act", int'($signed(out_act)), 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_vec(2'b11, act, z, act8, z8, lat);
      chk("post reset act", act, 0);
      chk("post reset z", z, 1);
      chk("post reset latency", lat, 2);

      // Overflow with an 8-bit accumulator
      cfg_all(127, 127, 0);
      run_vec(2'b11, act, z, act8, z8, lat);
      chk("wide 127+127 act", act, 254);
`ifdef SEQ_NEURON_SATURATE_EN
      chk("acc8 sat act", act8, 127);
      chk("acc8 sat z", z8, 1);
`else
      chk("acc8 wrap act", act8, -2);
      chk("acc8 wrap z", z8, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
